dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the single-cycle MIPS core's data port and a multi-cycle main memory with a req/ack handshake.
- Read hits return data combinationally in the same cycle.
- Read misses stall the core while the line is refilled one word at a time.
- Every write is forwarded to memory, and the core is stalled until memory acknowledges it.

---
 rtl/mips_mem_pkg.sv | 28 ++
 rtl/dcache_wt_if.sv | 26 ++
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache_wt.sv | 161 ++++++++++++++++
 tb/tb_dcache_wt.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ==================================================================
// mips_mem_pkg : shared types and byte/word helpers for the MIPS memory path
// Rev 1.0
// ==================================================================
package mips_mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      DC_IDLE   = 2'd0,
      DC_REFILL = 2'd1,
      DC_WRITE  = 2'd2
   } dc_state_t;

   // Element [0] is the most significant byte (big-endian core view).
   typedef logic [0:WORD_BYTES-1][7:0] byte_arr_t;

   function automatic logic [31:0] pack_word(input byte_arr_t b);
      return {b[0], b[1], b[2], b[3]};
   endfunction

   function automatic byte_arr_t unpack_word(input logic [31:0] w);
      return {w[31:24], w[23:16], w[15:8], w[7:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wt_if.sv
`default_nettype none
// ==================================================================
// dcache_wt_if : req/ack main-memory bus between cache (master) and memory (slave)
// Rev 1.0
// ==================================================================
interface dcache_wt_if;

   logic [31:0] mm_addr;
   logic [31:0] mm_wdata;
   logic        mm_we;
   logic        mm_req;
   logic        mm_ack;
   logic [31:0] mm_rdata;

   modport master (
      output mm_addr, mm_wdata, mm_we, mm_req,
      input  mm_ack, mm_rdata
   );

   modport slave (
      input  mm_addr, mm_wdata, mm_we, mm_req,
      output mm_ack, mm_rdata
   );

endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ==================================================================
// dcache_array : valid/tag/data storage, combinational read, synchronous writes
// Rev 1.0
// ==================================================================
module dcache_array
   import mips_mem_pkg::*;
#(
   parameter  int NUM_LINES  = 64,
   parameter  int LINE_WORDS = 4,
   parameter  int TAG_W      = 24,
   localparam int IDX_W      = $clog2(NUM_LINES),
   localparam int OFF_W      = $clog2(LINE_WORDS)
) (
   input  wire logic             clk,
   input  wire logic             rst_b,
   input  wire logic [IDX_W-1:0] rd_index,
   input  wire logic [OFF_W-1:0] rd_offset,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [31:0]           rd_word,
   input  wire logic             wr_en,
   input  wire logic [IDX_W-1:0] wr_index,
   input  wire logic [OFF_W-1:0] wr_offset,
   input  wire logic [31:0]      wr_word,
   input  wire logic             val_set,
   input  wire logic             val_clr,
   input  wire logic [IDX_W-1:0] val_index,
   input  wire logic [TAG_W-1:0] val_tag
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tags [NUM_LINES];
   logic [31:0]          r_data [NUM_LINES][LINE_WORDS];

   assign rd_valid = r_valid[rd_index];
   assign rd_tag   = r_tags[rd_index];
   assign rd_word  = r_data[rd_index][rd_offset];

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_valid <= '0;
      end else if (val_clr) begin
         r_valid[val_index] <= 1'b0;
      end else if (val_set) begin
         r_valid[val_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (val_set) begin
         r_tags[val_index] <= val_tag;
      end
      if (wr_en) begin
         r_data[wr_index][wr_offset] <= wr_word;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_wt.sv
`default_nettype none
// ==================================================================
// dcache_wt : direct-mapped write-through, no-write-allocate data cache
// Rev 1.0
// ==================================================================
module dcache_wt
   import mips_mem_pkg::*;
#(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_b,
   input  wire logic [31:0] core_addr,
   input  wire byte_arr_t   core_wdata,
   input  wire logic        core_we,
   input  wire logic        core_re,
   input  wire logic        halted,
   output byte_arr_t        core_rdata,
   output logic             stall,
   dcache_wt_if.master      mm,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

   dc_state_t        r_state;
   logic [OFF_W-1:0] r_cnt;
   logic             r_retry;

   logic [OFF_W-1:0] w_core_off, w_mm_off;
   logic [IDX_W-1:0] w_core_idx, w_mm_idx, w_val_idx;
   logic [TAG_W-1:0] w_core_tag, w_mm_tag, w_rd_tag;
   logic [31:0]      w_rd_word, w_wr_word;
   logic             w_rd_valid, w_hit, w_rd_hit, w_rd_miss, w_wr_start;
   logic             w_ack, w_refill_ack, w_write_ack, w_last, w_wr_en, w_val_set;
   logic             w_unused_addr;

   assign w_core_off    = core_addr[OFF_W+1:2];
   assign w_core_idx    = core_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_core_tag    = core_addr[31:OFF_W+IDX_W+2];
   assign w_mm_off      = mm.mm_addr[OFF_W+1:2];
   assign w_mm_idx      = mm.mm_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_mm_tag      = mm.mm_addr[31:OFF_W+IDX_W+2];
   assign w_unused_addr = ^core_addr[1:0];

   assign w_hit        = w_rd_valid && (w_rd_tag == w_core_tag);
   assign w_wr_start   = (r_state == DC_IDLE) && !halted && core_we;
   assign w_rd_hit     = (r_state == DC_IDLE) && !halted && !core_we && core_re && w_hit;
   assign w_rd_miss    = (r_state == DC_IDLE) && !halted && !core_we && core_re && !w_hit;
   assign w_ack        = mm.mm_ack && mm.mm_req;
   assign w_refill_ack = (r_state == DC_REFILL) && w_ack;
   assign w_write_ack  = (r_state == DC_WRITE) && w_ack;
   assign w_last       = (r_cnt == OFF_W'(LINE_WORDS - 1));

   // Stores only update a line that is already resident (no write-allocate).
   assign w_wr_en   = w_refill_ack || (w_write_ack && w_hit);
   assign w_wr_word = (r_state == DC_WRITE) ? mm.mm_wdata : mm.mm_rdata;
   assign w_val_set = w_refill_ack && w_last;
   assign w_val_idx = (r_state == DC_IDLE) ? w_core_idx : w_mm_idx;

   assign core_rdata = w_rd_hit ? unpack_word(w_rd_word) : '0;

   always_comb begin
      stall = 1'b0;
      case (r_state)
         DC_IDLE:   stall = w_wr_start || w_rd_miss;
         DC_REFILL: stall = 1'b1;
         DC_WRITE:  stall = !w_ack;
         default:   stall = 1'b0;
      endcase
   end

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst_b    (rst_b),
      .rd_index (w_core_idx),
      .rd_offset(w_core_off),
      .rd_valid (w_rd_valid),
      .rd_tag   (w_rd_tag),
      .rd_word  (w_rd_word),
      .wr_en    (w_wr_en),
      .wr_index (w_mm_idx),
      .wr_offset(w_mm_off),
      .wr_word  (w_wr_word),
      .val_set  (w_val_set),
      .val_clr  (w_rd_miss),
      .val_index(w_val_idx),
      .val_tag  (w_mm_tag)
   );

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_state      <= DC_IDLE;
         r_cnt        <= '0;
         r_retry      <= 1'b0;
         mm.mm_req    <= 1'b0;
         mm.mm_we     <= 1'b0;
         mm.mm_addr   <= '0;
         mm.mm_wdata  <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         r_retry <= 1'b0;
         case (r_state)
            DC_IDLE: begin
               if (w_wr_start) begin
                  r_state     <= DC_WRITE;
                  mm.mm_req   <= 1'b1;
                  mm.mm_we    <= 1'b1;
                  mm.mm_addr  <= {core_addr[31:2], 2'b00};
                  mm.mm_wdata <= pack_word(core_wdata);
               end else if (w_rd_miss) begin
                  r_state    <= DC_REFILL;
                  r_cnt      <= '0;
                  mm.mm_req  <= 1'b1;
                  mm.mm_we   <= 1'b0;
                  mm.mm_addr <= {w_core_tag, w_core_idx, {OFF_W{1'b0}}, 2'b00};
                  if (miss_count != 32'hFFFF_FFFF) begin
                     miss_count <= miss_count + 32'd1;
                  end
               end else if (w_rd_hit) begin
                  // The hit that retires a refilled load was already counted as a miss.
                  if (!r_retry && hit_count != 32'hFFFF_FFFF) begin
                     hit_count <= hit_count + 32'd1;
                  end
               end
            end
            DC_REFILL: begin
               if (w_ack) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state   <= DC_IDLE;
                     mm.mm_req <= 1'b0;
                     r_retry   <= 1'b1;
                  end else begin
                     mm.mm_addr <= {w_mm_tag, w_mm_idx, r_cnt + 1'b1, 2'b00};
                  end
               end
            end
            DC_WRITE: begin
               if (w_ack) begin
                  r_state   <= DC_IDLE;
                  mm.mm_req <= 1'b0;
                  mm.mm_we  <= 1'b0;
               end
            end
            default: r_state <= DC_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// tb_dcache_wt : directed tests of dcache_wt against a behavioural req/ack memory.
module tb_dcache_wt;
   import mips_mem_pkg::*;

   logic        clk;
   logic        rst_b;
   logic [31:0] core_addr;
   byte_arr_t   core_wdata;
   byte_arr_t   core_rdata;
   logic        core_we, core_re, halted, stall;
   logic [31:0] hit_count, miss_count;

   dcache_wt_if mm_if();

   dcache_wt #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .core_addr (core_addr),
      .core_wdata(core_wdata),
      .core_we   (core_we),
      .core_re   (core_re),
      .halted    (halted),
      .core_rdata(core_rdata),
      .stall     (stall),
      .mm        (mm_if),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   logic [31:0] mem       [0:4095];
   logic [31:0] log_addr  [0:63];
   logic        log_we    [0:63];
   logic [31:0] log_wdata [0:63];
   int log_n, ack_n, ack_delay, wait_cnt;
   int errors, checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: logs each request, acks ack_delay cycles after it is first seen.
   initial begin
      mm_if.mm_ack   = 1'b0;
      mm_if.mm_rdata = '0;
      wait_cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_b || mm_if.mm_ack) begin
            mm_if.mm_ack = 1'b0;
            wait_cnt     = 0;
         end else if (mm_if.mm_req) begin
            if (wait_cnt == 0 && log_n < 64) begin
               log_addr[log_n]  = mm_if.mm_addr;
               log_we[log_n]    = mm_if.mm_we;
               log_wdata[log_n] = mm_if.mm_wdata;
               log_n++;
            end
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               mm_if.mm_ack = 1'b1;
               ack_n++;
               if (mm_if.mm_we) mem[mm_if.mm_addr[13:2]] = mm_if.mm_wdata;
               else             mm_if.mm_rdata = mem[mm_if.mm_addr[13:2]];
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   function automatic logic [31:0] to_word(input byte_arr_t b);
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic access(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, output int cycles,
                         output byte_arr_t rb, output logic ack_seen);
      @(negedge clk);
      core_addr     = addr;
      core_we       = we;
      core_re       = re;
      core_wdata[0] = wd[31:24];
      core_wdata[1] = wd[23:16];
      core_wdata[2] = wd[15:8];
      core_wdata[3] = wd[7:0];
      cycles = 0;
      #1;
      while (stall === 1'b1 && cycles < 60) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      rb       = core_rdata;
      ack_seen = mm_if.mm_ack;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL access_timeout addr=%h: stall=%b after %0d cycles, required 0", addr, stall, cycles);
      end
      @(posedge clk);
      #1;
      core_we = 1'b0;
      core_re = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mm_if.mm_req !== 1'b0) begin errors++; $display("FAIL reset_mm_req: got %b required 0", mm_if.mm_req); end
      checks++; if (mm_if.mm_we !== 1'b0) begin errors++; $display("FAIL reset_mm_we: got %b required 0", mm_if.mm_we); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
      checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hits: got %0d required 0", hit_count); end
      checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_misses: got %0d required 0", miss_count); end
      checks++; if (to_word(core_rdata) !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h required 0", core_rdata); end
      @(negedge clk);
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (mm_if.mm_req !== 1'b0) begin errors++; $display("FAIL post_reset_idle: mm_req %b required 0", mm_if.mm_req); end
   endtask

   task automatic test_cold_miss();
      int cyc; byte_arr_t rb; logic ak;
      log_n = 0; ack_delay = 2;
      access(1'b0, 1'b1, 32'h0000_0104, 32'h0, cyc, rb, ak);
      checks++; if (cyc == 0) begin errors++; $display("FAIL cold_stall: stalled %0d cycles, required >0", cyc); end
      checks++; if (log_n !== 4) begin errors++; $display("FAIL cold_req_count: got %0d required 4", log_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_addr[i] !== 32'h100 + 32'(4 * i) || log_we[i] !== 1'b0) begin
            errors++;
            $display("FAIL cold_req_%0d: got addr %h we %b required addr %h we 0", i, log_addr[i], log_we[i], 32'h100 + 32'(4 * i));
         end
      end
      checks++; if (to_word(rb) !== 32'h2222_2222) begin errors++; $display("FAIL cold_rdata: got %h required 22222222", to_word(rb)); end
      checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_misses: got %0d required 1", miss_count); end
      checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL cold_hits: got %0d required 0", hit_count); end
   endtask

   task automatic test_read_hit();
      int cyc; byte_arr_t rb; logic ak; int n0;
      n0 = log_n;
      access(1'b0, 1'b1, 32'h0000_010C, 32'h0, cyc, rb, ak);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL hit_stall: stalled %0d cycles, required 0", cyc); end
      checks++; if (rb[0] !== 8'h44 || to_word(rb) !== 32'h4444_4444) begin errors++; $display("FAIL hit_rdata: got %h required 44444444", to_word(rb)); end
      checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_count: got %0d required 1", hit_count); end
      checks++; if (log_n !== n0) begin errors++; $display("FAIL hit_no_traffic: got %0d requests required %0d", log_n, n0); end
   endtask

   task automatic test_write_hit();
      int cyc; byte_arr_t rb; logic ak;
      log_n = 0; ack_delay = 3;
      access(1'b1, 1'b0, 32'h0000_0108, 32'hDEAD_BEEF, cyc, rb, ak);
      checks++; if (ak !== 1'b1) begin errors++; $display("FAIL write_stall_in_ack: ack %b when stall fell, required 1", ak); end
      checks++; if (cyc !== 3) begin errors++; $display("FAIL write_stall_cycles: got %0d required 3", cyc); end
      checks++; if (log_n !== 1) begin errors++; $display("FAIL write_req_count: got %0d required 1", log_n); end
      checks++;
      if (log_addr[0] !== 32'h108 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_req: got addr %h we %b data %h required 108 1 deadbeef", log_addr[0], log_we[0], log_wdata[0]);
      end
      ack_delay = 2;
      access(1'b0, 1'b1, 32'h0000_0108, 32'h0, cyc, rb, ak);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL write_then_hit: stalled %0d cycles, required 0", cyc); end
      checks++;
      if (rb[0] !== 8'hDE || rb[3] !== 8'hEF || to_word(rb) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_then_rdata: got %h required deadbeef", to_word(rb));
      end
      checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL write_hits: got %0d required 2", hit_count); end
      checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL write_misses: got %0d required 1", miss_count); end
   endtask

   task automatic test_conflict();
      int cyc; byte_arr_t rb; logic ak;
      log_n = 0; ack_delay = 2;
      access(1'b0, 1'b1, 32'h0000_0504, 32'h0, cyc, rb, ak);
      checks++; if (log_n !== 4 || log_addr[0] !== 32'h500) begin errors++; $display("FAIL conflict_refill: got %0d reqs first %h required 4 reqs first 500", log_n, log_addr[0]); end
      checks++; if (to_word(rb) !== 32'hC0DE_0504) begin errors++; $display("FAIL conflict_rdata: got %h required c0de0504", to_word(rb)); end
      checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL conflict_misses1: got %0d required 2", miss_count); end
      access(1'b0, 1'b1, 32'h0000_0104, 32'h0, cyc, rb, ak);
      checks++; if (cyc == 0 || log_n !== 8) begin errors++; $display("FAIL conflict_evict: stall %0d reqs %0d required >0 and 8", cyc, log_n); end
      checks++; if (to_word(rb) !== 32'h2222_2222) begin errors++; $display("FAIL conflict_rdata2: got %h required 22222222", to_word(rb)); end
      checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL conflict_misses2: got %0d required 3", miss_count); end
      checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL conflict_hits: got %0d required 2", hit_count); end
   endtask

   task automatic test_write_no_allocate();
      int cyc; byte_arr_t rb; logic ak;
      log_n = 0;
      access(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, cyc, rb, ak);
      checks++;
      if (log_n !== 1 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h2000) begin
         errors++;
         $display("FAIL noalloc_write: got %0d reqs we %b addr %h required 1 write at 2000", log_n, log_we[0], log_addr[0]);
      end
      checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL noalloc_misses1: got %0d required 3", miss_count); end
      access(1'b0, 1'b1, 32'h0000_2000, 32'h0, cyc, rb, ak);
      checks++; if (miss_count !== 32'd4) begin errors++; $display("FAIL noalloc_misses2: got %0d required 4", miss_count); end
      checks++;
      if (log_n !== 5 || log_addr[1] !== 32'h2000 || log_we[1] !== 1'b0) begin
         errors++;
         $display("FAIL noalloc_refill: got %0d reqs second %h we %b required 5 reqs second 2000 read", log_n, log_addr[1], log_we[1]);
      end
      checks++; if (to_word(rb) !== 32'h1234_5678) begin errors++; $display("FAIL noalloc_rdata: got %h required 12345678", to_word(rb)); end
   endtask

   task automatic test_reset_mid_refill();
      int cyc; byte_arr_t rb; logic ak; int guard;
      log_n = 0; ack_n = 0; ack_delay = 2;
      @(negedge clk);
      core_addr = 32'h0000_0304;
      core_re   = 1'b1;
      guard = 0;
      while (ack_n < 2 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++; if (ack_n < 2) begin errors++; $display("FAIL midrst_acks: got %0d acks required 2", ack_n); end
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      checks++; if (mm_if.mm_req !== 1'b0) begin errors++; $display("FAIL midrst_req_drop: got %b required 0", mm_if.mm_req); end
      core_re = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b required 0", stall); end
      checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL midrst_counter: got %0d required 0", miss_count); end
      @(negedge clk);
      rst_b = 1'b0;
      log_n = 0;
      access(1'b0, 1'b1, 32'h0000_0304, 32'h0, cyc, rb, ak);
      checks++;
      if (log_n !== 4 || log_addr[0] !== 32'h300 || log_addr[3] !== 32'h30C) begin
         errors++;
         $display("FAIL midrst_refill: got %0d reqs %h..%h required 4 reqs 300..30c", log_n, log_addr[0], log_addr[3]);
      end
      checks++; if (to_word(rb) !== 32'hC0DE_0304) begin errors++; $display("FAIL midrst_rdata: got %h required c0de0304", to_word(rb)); end
      checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL midrst_misses: got %0d required 1", miss_count); end
      access(1'b0, 1'b1, 32'h0000_010C, 32'h0, cyc, rb, ak);
      checks++; if (cyc == 0 || miss_count !== 32'd2) begin errors++; $display("FAIL midrst_invalidated: stall %0d misses %0d required >0 and 2", cyc, miss_count); end
      checks++; if (to_word(rb) !== 32'h4444_4444) begin errors++; $display("FAIL midrst_rdata2: got %h required 44444444", to_word(rb)); end
   endtask

   task automatic test_halted();
      log_n = 0;
      @(negedge clk);
      halted    = 1'b1;
      core_addr = 32'h0000_010C;
      core_we   = 1'b1;
      core_re   = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halted_stall: got %b required 0", stall); end
      checks++; if (to_word(core_rdata) !== 32'd0) begin errors++; $display("FAIL halted_rdata: got %h required 0", to_word(core_rdata)); end
      repeat (3) @(negedge clk);
      checks++; if (log_n !== 0) begin errors++; $display("FAIL halted_traffic: got %0d reqs required 0", log_n); end
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd2) begin errors++; $display("FAIL halted_counters: got hits %0d misses %0d required 0 and 2", hit_count, miss_count); end
      core_we = 1'b0;
      core_re = 1'b0;
      halted  = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      log_n     = 0;
      ack_n     = 0;
      ack_delay = 2;
      for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
      mem[12'h040] = 32'h1111_1111;
      mem[12'h041] = 32'h2222_2222;
      mem[12'h042] = 32'h3333_3333;
      mem[12'h043] = 32'h4444_4444;
      rst_b      = 1'b1;
      core_addr  = '0;
      core_wdata = '0;
      core_we    = 1'b0;
      core_re    = 1'b0;
      halted     = 1'b0;

      test_reset();
      test_cold_miss();
      test_read_hit();
      test_write_hit();
      test_conflict();
      test_write_no_allocate();
      test_reset_mid_refill();
      test_halted();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
